// File: rtl/forest_pkg.sv
// Shared types and sizing helpers for the forest vote sequencer and its argmax.
package forest_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EVAL    = 2'd1,
    RESOLVE = 2'd2,
    DONE    = 2'd3
  } state_e;

  localparam int DEF_N_FEAT    = 51;
  localparam int DEF_N_CLASSES = 3;
  localparam int DEF_N_TREES   = 4;

  // Bits needed to index n distinct values, never less than one.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vote_argmax.sv
// Combinational argmax over the per-class vote counters; the lowest class index wins ties.
module vote_argmax
  import forest_pkg::*;
#(
  parameter int  N_CLASSES = DEF_N_CLASSES,
  parameter int  CNT_W     = idx_width(DEF_N_TREES + 1),
  localparam int CLS_W     = $clog2(N_CLASSES)
) (
  input  logic [N_CLASSES-1:0][CNT_W-1:0] votes_i,
  output logic [CLS_W-1:0]                win_cls_o,
  output logic [CNT_W-1:0]                win_cnt_o
);

  logic [CLS_W-1:0] best_cls;
  logic [CNT_W-1:0] best_cnt;

  // Strict greater-than keeps the earlier class on equal counts.
  always_comb begin
    best_cls = '0;
    best_cnt = votes_i[0];
    for (int i = 1; i < N_CLASSES; i++) begin
      if (votes_i[i] > best_cnt) begin
        best_cls = CLS_W'(i);
        best_cnt = votes_i[i];
      end
    end
  end

  assign win_cls_o = best_cls;
  assign win_cnt_o = best_cnt;

endmodule

// File: rtl/forest_vote_sequencer.sv
// Walks the tree-output mux over every (class, tree) pair, counts votes per class
// and hands the winning class to the consumer over valid/ready.
module forest_vote_sequencer
  import forest_pkg::*;
#(
  parameter int  N_FEAT    = DEF_N_FEAT,
  parameter int  N_CLASSES = DEF_N_CLASSES,
  parameter int  N_TREES   = DEF_N_TREES,
  localparam int CLS_W     = $clog2(N_CLASSES),
  localparam int TREE_W    = idx_width(N_TREES),
  localparam int CNT_W     = idx_width(N_TREES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_FEAT-1:0] in_feat,
  output logic [N_FEAT-1:0] feat_q,
  output logic [CLS_W-1:0]  cls_sel,
  output logic [TREE_W-1:0] tree_sel,
  input  logic              tree_bit,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CLS_W-1:0]  out_class,
  output logic [CNT_W-1:0]  out_votes,
  output logic              busy
);

  localparam logic [TREE_W-1:0] TREE_LAST = TREE_W'(N_TREES - 1);
  localparam logic [CLS_W-1:0]  CLS_LAST  = CLS_W'(N_CLASSES - 1);

  state_e                          state_q, state_d;
  logic [N_FEAT-1:0]               feat_d;
  logic [CLS_W-1:0]                cls_sel_q, cls_sel_d;
  logic [TREE_W-1:0]               tree_sel_q, tree_sel_d;
  logic [CLS_W-1:0]                out_class_q, out_class_d;
  logic [CNT_W-1:0]                out_votes_q, out_votes_d;
  logic [N_CLASSES-1:0][CNT_W-1:0] votes;
  logic                            votes_clr;
  logic                            votes_en;
  logic [CLS_W-1:0]                win_cls;
  logic [CNT_W-1:0]                win_cnt;

  for (genvar gi = 0; gi < N_CLASSES; gi++) begin : g_vote
    logic [CNT_W-1:0] cnt_q;
    logic             hit;

    assign hit = votes_en && tree_bit && (cls_sel_q == CLS_W'(gi));

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q <= '0;
      end else if (votes_clr) begin
        cnt_q <= '0;
      end else if (hit) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end

    assign votes[gi] = cnt_q;
  end

  vote_argmax #(
    .N_CLASSES (N_CLASSES),
    .CNT_W     (CNT_W)
  ) u_argmax (
    .votes_i   (votes),
    .win_cls_o (win_cls),
    .win_cnt_o (win_cnt)
  );

  always_comb begin
    state_d     = state_q;
    feat_d      = feat_q;
    cls_sel_d   = cls_sel_q;
    tree_sel_d  = tree_sel_q;
    out_class_d = out_class_q;
    out_votes_d = out_votes_q;
    votes_clr   = 1'b0;
    votes_en    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          feat_d     = in_feat;
          votes_clr  = 1'b1;
          cls_sel_d  = '0;
          tree_sel_d = '0;
          state_d    = EVAL;
        end
      end
      EVAL: begin
        votes_en = 1'b1;
        // The last pair leaves the selects parked where they are.
        if (tree_sel_q == TREE_LAST) begin
          if (cls_sel_q == CLS_LAST) begin
            state_d = RESOLVE;
          end else begin
            tree_sel_d = '0;
            cls_sel_d  = cls_sel_q + CLS_W'(1);
          end
        end else begin
          tree_sel_d = tree_sel_q + TREE_W'(1);
        end
      end
      RESOLVE: begin
        out_class_d = win_cls;
        out_votes_d = win_cnt;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      feat_q      <= '0;
      cls_sel_q   <= '0;
      tree_sel_q  <= '0;
      out_class_q <= '0;
      out_votes_q <= '0;
    end else begin
      state_q     <= state_d;
      feat_q      <= feat_d;
      cls_sel_q   <= cls_sel_d;
      tree_sel_q  <= tree_sel_d;
      out_class_q <= out_class_d;
      out_votes_q <= out_votes_d;
    end
  end

  // in_ready is gated by rst so nothing can be accepted while reset is held.
  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign cls_sel   = cls_sel_q;
  assign tree_sel  = tree_sel_q;
  assign out_class = out_class_q;
  assign out_votes = out_votes_q;

endmodule

// File: tb/tb_forest_vote_sequencer.sv
// Directed bench: a bit pattern stands in for the 12 trees, expected winners are hand-computed.
module tb_forest_vote_sequencer;

  localparam int NF = 51;
  localparam int NT = 4;
  localparam int NS = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [NF-1:0] in_feat;
  logic [NF-1:0] feat_q;
  logic [1:0]    cls_sel;
  logic [1:0]    tree_sel;
  logic          tree_bit;
  logic          out_valid;
  logic          out_ready;
  logic [1:0]    out_class;
  logic [2:0]    out_votes;
  logic          busy;
  logic [15:0]   tree_pat;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  int last_acc     = 0;
  int acc_gap      = 0;

  localparam logic [NF-1:0] FEAT_A = 51'h5_A5A5_1234_5678;
  localparam logic [NF-1:0] FEAT_B = 51'h1_0F0F_CAFE_0001;
  localparam logic [NF-1:0] FEAT_C = 51'h7_FFFF_0000_FFFF;
  localparam logic [NF-1:0] FEAT_G = 51'h3_1357_9BDF_2468;
  localparam logic [NF-1:0] FEAT_N = 51'h6_8642_FDB9_7531;

  always #5 clk = ~clk;

  // Trees are indexed as cls*4 + tree, which with NT=4 is just {cls, tree}.
  always_comb tree_bit = tree_pat[{cls_sel, tree_sel}];

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (in_valid && in_ready) begin
      acc_gap  = cyc - last_acc;
      last_acc = cyc;
    end
  end

  forest_vote_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_feat   (in_feat),
    .feat_q    (feat_q),
    .cls_sel   (cls_sel),
    .tree_sel  (tree_sel),
    .tree_bit  (tree_bit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_class (out_class),
    .out_votes (out_votes),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic sample(input logic [NF-1:0] feat, input logic [11:0] pat,
                        input logic [1:0] exp_cls, input logic [2:0] exp_votes,
                        input bit chk_order, input bit chk_gap);
    bit acc = 1'b0;
    bit got = 1'b0;
    int lat = 0;
    tree_pat = {4'b0000, pat};
    in_feat  = feat;
    in_valid = 1'b1;
    for (int k = 0; k < 40 && !acc; k++) begin
      if (in_ready) acc = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("accepted", 64'(acc), 64'(1));
    check("feat_q", 64'(feat_q), 64'(feat));
    check("busy", 64'(busy), 64'(1));
    check("in_ready_busy", 64'(in_ready), 64'(0));
    if (chk_gap) check("accept_gap", 64'(acc_gap), 64'(15));
    for (int k = 1; k <= 40 && !got; k++) begin
      if (chk_order && k <= NS) begin
        check("cls_sel_order", 64'(cls_sel), 64'((k - 1) / NT));
        check("tree_sel_order", 64'(tree_sel), 64'((k - 1) % NT));
      end
      @(posedge clk); #1;
      if (out_valid) begin
        got = 1'b1;
        lat = k;
      end
    end
    check("latency", 64'(lat), 64'(13));
    check("out_class", 64'(out_class), 64'(exp_cls));
    check("out_votes", 64'(out_votes), 64'(exp_votes));
    check("in_ready_done", 64'(in_ready), 64'(0));
    $display("[TB] sample feat=%h pat=%h -> class %0d votes %0d after %0d edges",
             feat, pat, out_class, out_votes, lat);
    if (out_ready) begin
      @(posedge clk); #1;
      check("out_valid_drop", 64'(out_valid), 64'(0));
      check("in_ready_back", 64'(in_ready), 64'(1));
    end
  endtask

  initial begin
    int ov;
    int c;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_feat   = '0;
    out_ready = 1'b1;
    tree_pat  = '0;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'(0));
    repeat (2) begin @(posedge clk); #1; end
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_feat_q", 64'(feat_q), 64'(0));
    check("rst_sel", 64'({cls_sel, tree_sel}), 64'(0));
    check("rst_out", 64'({out_class, out_votes}), 64'(0));
    rst = 1'b0;
    #1;
    check("rel_in_ready", 64'(in_ready), 64'(1));

    // Only class 2 trees fire.
    sample(FEAT_A, 12'hF00, 2'd2, 3'd4, 1'b1, 1'b0);

    // Reset in the middle of EVAL abandons the sample.
    tree_pat = 16'h0FFF;
    in_feat  = FEAT_B;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("mid_busy", 64'(busy), 64'(1));
    repeat (4) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1;
    check("mid_rst_in_ready", 64'(in_ready), 64'(0));
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_feat_q", 64'(feat_q), 64'(0));
    check("mid_rst_sel", 64'({cls_sel, tree_sel}), 64'(0));
    check("mid_rst_out", 64'({out_class, out_votes}), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("mid_rel_in_ready", 64'(in_ready), 64'(1));
    ov = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid) ov++;
    end
    check("mid_no_out_valid", 64'(ov), 64'(0));
    $display("[TB] reset mid-EVAL: out_valid pulses afterwards = %0d", ov);

    // Class 0 trees 0,1 and class 1 trees 2,3: tie resolves to class 0.
    sample(FEAT_B, 12'h0C3, 2'd0, 3'd2, 1'b0, 1'b0);
    // No tree fires; also re-walk the select order.
    sample(FEAT_C, 12'h000, 2'd0, 3'd0, 1'b1, 1'b0);

    // Hold the result for 10 cycles while a new vector is offered.
    out_ready = 1'b0;
    sample(FEAT_G, 12'hE01, 2'd2, 3'd3, 1'b0, 1'b1);
    for (int k = 0; k < 10; k++) begin
      if (k == 2) begin
        in_valid = 1'b1;
        in_feat  = FEAT_N;
      end
      check("hold_out_valid", 64'(out_valid), 64'(1));
      check("hold_out_class", 64'({out_class, out_votes}), 64'({2'd2, 3'd3}));
      check("hold_in_ready", 64'(in_ready), 64'(0));
      check("hold_feat_q", 64'(feat_q), 64'(FEAT_G));
      @(posedge clk); #1;
    end
    c = cyc;
    out_ready = 1'b1;
    sample(FEAT_N, 12'h070, 2'd1, 3'd3, 1'b0, 1'b0);
    check("accept_after_ready", 64'(last_acc), 64'(c + 2));

    // Back-to-back samples with the consumer always ready.
    sample(FEAT_A, 12'h0F0, 2'd1, 3'd4, 1'b0, 1'b1);
    sample(FEAT_B, 12'h1E1, 2'd1, 3'd3, 1'b0, 1'b1);
    sample(FEAT_C, 12'hE3E, 2'd0, 3'd3, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/forest_vote_sequencer.md
# forest_vote_sequencer

Sequencer for one-vs-rest decision-tree ensembles built from combinational tree blocks such as class0_tree2. It accepts a feature vector via valid/ready and holds it stable on the trees. It then steps a (class, tree) select through every tree output, one per clock, and accumulates one vote count per class. The winning class is presented on a valid/ready output. It sits between the feature source and the system consumer, and it owns the external tree-output mux select.

## Interface
- N_FEAT, 51, feature vector width (bit i feeds tree input i)
- N_CLASSES, 3, number of classes (≥2)
- N_TREES, 4, trees per class (≥1)
- CLS_W, $clog2(N_CLASSES), class index width
- TREE_W, max(1,$clog2(N_TREES)), tree index width
- CNT_W, $clog2(N_TREES+1), per-class vote counter width
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  feature vector offered
- in_ready  out  1  sequencer accepts a vector
- in_feat  in  N_FEAT  feature vector
- feat_q  out  N_FEAT  registered features, driven to all trees
- cls_sel  out  CLS_W  class of the tree currently selected
- tree_sel  out  TREE_W  tree index within that class
- tree_bit  in  1  output of the selected tree (combinational from feat_q/selects)
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- out_class  out  CLS_W  winning class
- out_votes  out  CNT_W  vote count of the winner
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, EVAL, RESOLVE, DONE.
- IDLE behaviour:
  - in_ready=1.
  - When in_valid&in_ready is seen at a rising edge: latch feat_q←in_feat, clear all counters, set cls_sel=0 and tree_sel=0, then go to EVAL.
- EVAL behaviour:
  - Each cycle: votes[cls_sel] += tree_bit.
  - tree_sel increments. When it reaches N_TREES-1 it wraps to 0 and cls_sel increments.
  - After the (N_CLASSES-1, N_TREES-1) step: go to RESOLVE. Selects stay at that final value.
- RESOLVE (one cycle): register the argmax over votes into out_class/out_votes.
  - Ties go to the lowest class index.
  - If every count is 0, the result is class 0 with 0 votes.
- DONE behaviour:
  - out_valid=1. out_class and out_votes are held stable.
  - When out_valid&out_ready is seen at a rising edge: go to IDLE.
- in_ready is 0 in every state except IDLE. There is no pipelining across samples.
- feat_q changes only on accept.
- Counters cannot overflow (max value N_TREES); addition is unsigned and CNT_W wide.

## Timing
- Reset values: state IDLE; feat_q, cls_sel, tree_sel, out_class, out_votes, out_valid and busy are all 0. in_ready is forced to 0 while rst is high and becomes 1 in the first cycle after deassertion.
- Accept edge = E0.
  - EVAL occupies cycles E0+1 … E0+N_CLASSES·N_TREES.
  - RESOLVE follows.
  - out_valid rises after edge E0+N_CLASSES·N_TREES+1.
  - Default latency is 13 edges to out_valid.
- tree_bit is sampled at the end of each EVAL cycle. The tree path must settle within one cycle of a select change.
- out_ready held high in DONE: out_valid lasts exactly one cycle, and in_ready rises the next cycle. Minimum sample period is N_CLASSES·N_TREES+3 cycles.
- in_valid in a non-IDLE state is ignored; the source must hold it.
- rst asserted mid-sample: the sample is abandoned immediately and no out_valid is produced.

## Structure
- Package forest_pkg holds:
  - state enum (IDLE, EVAL, RESOLVE, DONE);
  - default N_FEAT, N_CLASSES, N_TREES;
  - width helper function for CNT_W/TREE_W.
- Sub-module vote_argmax: combinational, input is the packed vote array, outputs are the winner index and its count, lowest index wins ties. It is instantiated once, ahead of the RESOLVE registers.
- The tree-output mux and the tree instances stay outside this block.

## Test plan
- Reset mid-EVAL (rst pulse at E0+5): out_valid never rises, in_ready returns 1 after deassert, all outputs 0.
- Defaults; tree_bit=1 only when cls_sel=2 → out_class=2, out_votes=4, out_valid after edge E0+13.
- tree_bit=1 for trees 0,1 of class 0 and trees 2,3 of class 1 (tie 2–2) → out_class=0, out_votes=2.
- tree_bit always 0 → out_class=0, out_votes=0. Check the select order (0,0),(0,1)…(2,3), one step per cycle.
- out_ready held low for 10 cycles in DONE:
  - out_valid and out_class stay stable and in_ready stays 0;
  - a new in_valid with changed in_feat during this time leaves feat_q unchanged;
  - that vector is accepted the cycle after out_ready rises.
- Back-to-back samples with out_ready=1: accepts occur exactly 15 cycles apart, and each result matches the scoreboard.
